// File: rtl/su_pkg.sv
// -----------------------------------------------------------------------------
// su_pkg
// Shared constants, vector type and parity helper for the 2-bit sum unit.
//   SU_WIDTH    : number of sum bits handled by su_2bits
//   su_vec_t    : vector type used for c, p and s
//   su_even_par : even parity of a sum vector (XOR of all bits)
// -----------------------------------------------------------------------------
package su_pkg;

    localparam int SU_WIDTH = 2;

    typedef logic [SU_WIDTH-1:0] su_vec_t;

    // Even parity bit: 1 when the vector holds an odd number of ones, so
    // that vector plus parity always carries an even count.
    function automatic logic su_even_par(input su_vec_t vec);
        return ^vec;
    endfunction

endpackage

// File: rtl/su_2bits_if.sv
// -----------------------------------------------------------------------------
// su_2bits_if
// Operand/result bundle of the 2-bit sum unit.
//   in_valid  : c/p operands valid this cycle
//   c         : carry-in per bit from the carry-lookahead unit (c[0] = LSB)
//   p         : propagate per bit, a XOR b (p[0] = LSB)
//   out_valid : s is valid
//   s         : sum bits (s[0] = LSB)
//   par       : even parity of s, only when SU_2BITS_PARITY_EN is defined
// Modports: master drives operands (upstream / bench), slave is the unit.
// -----------------------------------------------------------------------------
interface su_2bits_if;
    import su_pkg::*;

    logic    in_valid;
    su_vec_t c;
    su_vec_t p;
    logic    out_valid;
    su_vec_t s;
`ifdef SU_2BITS_PARITY_EN
    logic    par;

    modport master (output in_valid, output c, output p,
                    input  out_valid, input s, input par);
    modport slave  (input  in_valid, input c, input p,
                    output out_valid, output s, output par);
`else
    modport master (output in_valid, output c, output p,
                    input  out_valid, input s);
    modport slave  (input  in_valid, input c, input p,
                    output out_valid, output s);
`endif

endinterface

// File: rtl/su_1bit.sv
// -----------------------------------------------------------------------------
// su_1bit
// Single-bit sum cell: s = p XOR c. The carry has already been resolved by
// the lookahead unit, so no carry leaves this cell.
//   c : carry-in for this bit position
//   p : propagate for this bit position
//   s : sum bit
// -----------------------------------------------------------------------------
module su_1bit (
    input  logic c,
    input  logic p,
    output logic s
);

    assign s = p ^ c;

endmodule

// File: rtl/su_2bits.sv
// -----------------------------------------------------------------------------
// su_2bits
// 2-bit sum unit of a carry-lookahead adder: s[i] = p[i] XOR c[i], bits fully
// independent. With OUT_REG=1 the result is registered (1-cycle latency,
// one result per cycle, s holds while in_valid is low). With OUT_REG=0 the
// result is purely combinational and clk/rst_n are ignored.
// Optional feature macro: SU_2BITS_PARITY_EN adds par = even parity of s,
// following s in latency and reset.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : su_2bits_if.slave (in_valid, c, p, out_valid, s [, par])
// -----------------------------------------------------------------------------
module su_2bits
    import su_pkg::*;
#(
    parameter bit OUT_REG = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    su_2bits_if.slave  bus
);

    su_vec_t sum_s;

    for (genvar i = 0; i < SU_WIDTH; i++) begin : g_bit
        su_1bit u_bit (
            .c (bus.c[i]),
            .p (bus.p[i]),
            .s (sum_s[i])
        );
    end

    if (OUT_REG == 1'b1) begin : g_reg
        su_vec_t s_r;
        logic    out_valid_r;

        // Result register: capture on valid, hold otherwise; valid follows in_valid.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s_r         <= 2'b00;
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= bus.in_valid;
                if (bus.in_valid) begin
                    s_r <= sum_s;
                end else begin
                    s_r <= s_r;
                end
            end
        end

        assign bus.s         = s_r;
        assign bus.out_valid = out_valid_r;

`ifdef SU_2BITS_PARITY_EN
        logic par_r;

        // Parity register, loaded alongside s_r so it never disagrees with s.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                par_r <= 1'b0;
            end else if (bus.in_valid) begin
                par_r <= su_even_par(sum_s);
            end else begin
                par_r <= par_r;
            end
        end

        assign bus.par = par_r;
`endif
    end else begin : g_comb
        // Clock and reset have no role in the combinational build.
        logic unused_clk_rst_s;
        assign unused_clk_rst_s = clk & rst_n;

        assign bus.s         = sum_s;
        assign bus.out_valid = bus.in_valid;
`ifdef SU_2BITS_PARITY_EN
        assign bus.par       = su_even_par(sum_s);
`endif
    end

endmodule

// File: tb/tb_su_2bits.sv
// -----------------------------------------------------------------------------
// tb_su_2bits
// Bench for su_2bits: one registered instance (OUT_REG=1) and one
// combinational instance (OUT_REG=0) driven with the same operands.
// -----------------------------------------------------------------------------
module tb_su_2bits;
    import su_pkg::*;

    logic clk;
    logic rst_n;

    su_2bits_if bus_reg ();
    su_2bits_if bus_comb ();

    su_2bits #(.OUT_REG(1'b1)) dut_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_reg)
    );

    su_2bits #(.OUT_REG(1'b0)) dut_comb (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_comb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic    in_valid;
        su_vec_t c;
        su_vec_t p;
        su_vec_t exp_s;     // registered s after the edge
        logic    exp_ov;    // registered out_valid after the edge
        su_vec_t exp_comb;  // combinational s in the same cycle
    } vec_t;

    localparam int NVEC = 13;
    vec_t tbl [NVEC];

    int checks = 0;
    int errors = 0;
    logic [3:0] sb_q [$];

    // Pack {out_valid, par, s}; par is 0 when the parity feature is absent.
    function automatic logic [3:0] exp_pack(input logic ov, input su_vec_t s);
        logic par;
`ifdef SU_2BITS_PARITY_EN
        par = s[1] ^ s[0];
`else
        par = 1'b0;
`endif
        return {ov, par, s};
    endfunction

    function automatic logic [3:0] act_reg();
        logic par;
`ifdef SU_2BITS_PARITY_EN
        par = bus_reg.par;
`else
        par = 1'b0;
`endif
        return {bus_reg.out_valid, par, bus_reg.s};
    endfunction

    function automatic logic [3:0] act_comb();
        logic par;
`ifdef SU_2BITS_PARITY_EN
        par = bus_comb.par;
`else
        par = 1'b0;
`endif
        return {bus_comb.out_valid, par, bus_comb.s};
    endfunction

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got {ov,par,s}=%b expected %b at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input su_vec_t cc, input su_vec_t pp);
        bus_reg.in_valid  = v;
        bus_reg.c         = cc;
        bus_reg.p         = pp;
        bus_comb.in_valid = v;
        bus_comb.c        = cc;
        bus_comb.p        = pp;
    endtask

    // Drive at negedge, push the expectation, compare after the next rising edge.
    task automatic step(input string name, input logic v, input su_vec_t cc,
                        input su_vec_t pp, input logic [3:0] exp);
        logic [3:0] e;
        @(negedge clk);
        drive(v, cc, pp);
        sb_q.push_back(exp);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk(name, act_reg(), e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //             v     c      p      exp_s  ov     comb
        tbl[0]  = '{1'b1, 2'b00, 2'b00, 2'b00, 1'b1, 2'b00};
        tbl[1]  = '{1'b1, 2'b00, 2'b11, 2'b11, 1'b1, 2'b11};
        tbl[2]  = '{1'b1, 2'b11, 2'b00, 2'b11, 1'b1, 2'b11};
        tbl[3]  = '{1'b1, 2'b11, 2'b11, 2'b00, 1'b1, 2'b00};
        tbl[4]  = '{1'b1, 2'b01, 2'b11, 2'b10, 1'b1, 2'b10};
        tbl[5]  = '{1'b1, 2'b10, 2'b01, 2'b11, 1'b1, 2'b11};
        tbl[6]  = '{1'b1, 2'b01, 2'b01, 2'b00, 1'b1, 2'b00};
        tbl[7]  = '{1'b1, 2'b10, 2'b10, 2'b00, 1'b1, 2'b00};
        tbl[8]  = '{1'b1, 2'b01, 2'b00, 2'b01, 1'b1, 2'b01};
        tbl[9]  = '{1'b1, 2'b00, 2'b11, 2'b11, 1'b1, 2'b11};
        tbl[10] = '{1'b0, 2'b01, 2'b00, 2'b11, 1'b0, 2'b01};
        tbl[11] = '{1'b0, 2'b10, 2'b10, 2'b11, 1'b0, 2'b00};
        tbl[12] = '{1'b0, 2'b00, 2'b10, 2'b11, 1'b0, 2'b10};

        // Reset held from time 0 with a valid operand present: nothing captured.
        rst_n = 1'b0;
        drive(1'b1, 2'b00, 2'b11);
        #1;
        chk("reset_immediate", act_reg(), exp_pack(1'b0, 2'b00));
        chk("comb_in_reset", act_comb(), exp_pack(1'b1, 2'b11));
        @(posedge clk);
        #1;
        chk("reset_held_edge", act_reg(), exp_pack(1'b0, 2'b00));

        @(negedge clk);
        drive(1'b0, 2'b00, 2'b00);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("after_release_idle", act_reg(), exp_pack(1'b0, 2'b00));

        // Table: back-to-back valid results, then three idle cycles of hold.
        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            drive(tbl[i].in_valid, tbl[i].c, tbl[i].p);
            sb_q.push_back(exp_pack(tbl[i].exp_ov, tbl[i].exp_s));
            #1;
            chk($sformatf("comb_vec%0d", i), act_comb(),
                exp_pack(tbl[i].in_valid, tbl[i].exp_comb));
            @(posedge clk);
            #1;
            chk($sformatf("reg_vec%0d", i), act_reg(), sb_q.pop_front());
        end

        // Mid-stream reset while s=11 with another operand in flight.
        step("pre_reset_s11", 1'b1, 2'b00, 2'b11, exp_pack(1'b1, 2'b11));
        @(negedge clk);
        drive(1'b1, 2'b01, 2'b00);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midstream_reset_immediate", act_reg(), exp_pack(1'b0, 2'b00));
        @(posedge clk);
        #1;
        chk("midstream_reset_edge", act_reg(), exp_pack(1'b0, 2'b00));
        @(negedge clk);
        drive(1'b0, 2'b01, 2'b00);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("in_flight_discarded", act_reg(), exp_pack(1'b0, 2'b00));
        step("post_reset_s10", 1'b1, 2'b10, 2'b00, exp_pack(1'b1, 2'b10));
        step("post_reset_hold", 1'b0, 2'b11, 2'b10, exp_pack(1'b0, 2'b10));

        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/su_2bits.md
SU_2BITS -- requirements
Module: su_2bits

Interface
REQ-001 Parameter: OUT_REG, default 1, meaning 1 = registered outputs with 1-cycle latency, 0 = combinational outputs with 0-cycle latency.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 Port: in_valid  input  1  c/p operands valid this cycle.
REQ-005 Port: c  input  2  carry-in per bit position from the carry-lookahead unit; c[0] is the LSB.
REQ-006 Port: p  input  2  propagate per bit position (a XOR b); p[0] is the LSB.
REQ-007 Port: out_valid  output  1  s is valid.
REQ-008 Port: s  output  2  sum bits; s[0] is the LSB.
REQ-009 Port: par  output  1  even parity of s; present only when SU_2BITS_PARITY_EN is defined.

Function
REQ-010 Each bit SHALL compute s[i] = p[i] XOR c[i], independently for i = 0 and i = 1, with no inter-bit carry.
REQ-011 Truth table per bit SHALL be: (c,p) 0,0->0; 0,1->1; 1,0->1; 1,1->0.
REQ-012 With OUT_REG=1, when in_valid=1 at a rising edge, s SHALL take p^c and out_valid SHALL be 1 after that edge.
REQ-013 With OUT_REG=1, when in_valid=0 at a rising edge, s SHALL hold its previous value and out_valid SHALL go to 0.
REQ-014 With OUT_REG=1 and in_valid held high, a new result SHALL be produced every cycle (throughput 1/cycle, no back-pressure).
REQ-015 With OUT_REG=0, s SHALL equal p^c combinationally and out_valid SHALL equal in_valid; clk and rst_n have no effect.
REQ-016 X/Z handling is not required; inputs are assumed to be 2-state.

Reset
REQ-017 While rst_n=0 with OUT_REG=1, s SHALL be 2'b00, out_valid SHALL be 0, and par (if present) SHALL be 0, immediately and without waiting for clk.
REQ-018 If reset asserts mid-stream, any result in flight SHALL be discarded; the first valid output SHALL follow the first in_valid=1 edge after rst_n deasserts.
REQ-019 The reset deassertion edge SHALL NOT itself capture an operand.

Configuration
REQ-020 When macro SU_2BITS_PARITY_EN is defined, port par SHALL exist and equal s[1] XOR s[0], with the same latency and reset behaviour as s.
REQ-021 When SU_2BITS_PARITY_EN is undefined, port par and its logic SHALL be absent, and all other behaviour SHALL be unchanged.

Structure
REQ-022 Package su_pkg SHALL hold the constant SU_WIDTH = 2 and the typedef su_vec_t (logic [SU_WIDTH-1:0]); ports c, p and s SHALL use su_vec_t.
REQ-023 Sub-module su_1bit SHALL implement the per-bit combinational XOR (s = p ^ c) and SHALL be instantiated once per bit via generate.
REQ-024 The output register stage and the OUT_REG selection SHALL reside in su_2bits.

Verification
REQ-025 OUT_REG=1, in_valid=1, c=00, p=00 -> next cycle s=00, out_valid=1.
REQ-026 Back-to-back: c=00,p=11 then c=11,p=00 then c=11,p=11 -> s=11, 11, 00 on successive cycles, with out_valid=1 throughout.
REQ-027 Mixed bits: c=01, p=11 -> s=10 (bit 0 = 0, bit 1 = 1), confirming bit independence.
REQ-028 After s=11, drive in_valid=0 for 3 cycles -> s stays 11 and out_valid=0.
REQ-029 Assert rst_n=0 asynchronously between clock edges while s=11 -> s=00 and out_valid=0 immediately; release, then drive c=10, p=00 -> s=10.
REQ-030 With SU_2BITS_PARITY_EN defined: s=01 -> par=1; s=11 -> par=0. With OUT_REG=0: s tracks p^c in the same cycle.
